// File: rtl/core.sv
// WebAssembly-subset stack machine: each instruction is one FETCH cycle and one EXEC
// cycle over an 8-entry operand stack of 64-bit values with 2-bit type tags.
module core #(
    parameter int HAS_FPU   = 1,
    parameter int USE_64B   = 1,
    parameter int MEM_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [63:0]          result,
    output logic [1:0]           result_type,
    output logic                 result_empty,
    output logic [3:0]           trap,
    output logic [MEM_DEPTH:0]   mem_addr,
    output logic [3:0]           mem_extra,
    input  logic [127:0]         mem_data,
    input  logic                 mem_error,
    output logic [1:0]           o_dbg_state
);
    localparam int PC_W = MEM_DEPTH + 1;

    localparam logic [3:0] TRAP_RUN   = 4'd0;
    localparam logic [3:0] TRAP_END   = 4'd1;
    localparam logic [3:0] TRAP_UNDER = 4'd2;
    localparam logic [3:0] TRAP_OVER  = 4'd3;
    localparam logic [3:0] TRAP_UNK   = 4'd4;
    localparam logic [3:0] TRAP_MEM   = 4'd5;
    localparam logic [3:0] TRAP_TYPE  = 4'd6;

    localparam logic [1:0] T_I32 = 2'd0;
    localparam logic [1:0] T_I64 = 2'd1;
    localparam logic [1:0] T_F32 = 2'd2;
    localparam logic [1:0] T_F64 = 2'd3;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // Declaration initialisers match the reset values so the core also runs from power-on.
    state_t            r_state = S_FETCH;
    logic [PC_W-1:0]   r_pc    = '0;
    logic [3:0]        r_sp    = 4'd0;
    logic [3:0]        r_trap  = 4'd0;
    logic [63:0]       r_val  [0:7] = '{default: 64'd0};
    logic [1:0]        r_type [0:7] = '{default: 2'd0};

    state_t            w_state_next;
    logic [7:0]        w_opcode;
    logic [2:0]        w_top_idx;
    logic [2:0]        w_sec_idx;
    logic [31:0]       w_a;
    logic [31:0]       w_b;
    logic [31:0]       w_alu;
    logic              w_a_i32;
    logic              w_b_i32;
    logic              w_full;
    logic              w_empty;
    logic [67:0]       w_leb32;
    logic [67:0]       w_leb64;
    logic [3:0]        w_exec_trap;
    logic              w_wr_en;
    logic [2:0]        w_wr_idx;
    logic [63:0]       w_wr_val;
    logic [1:0]        w_wr_type;
    logic [3:0]        w_sp_next;
    logic [3:0]        w_len;
    logic              w_unused;

    // Signed LEB128 decode of up to maxn bytes; returns {byte_count, sign-extended value}.
    function automatic logic [67:0] leb_decode(input logic [79:0] b, input int maxn);
        logic [63:0] v;
        logic [3:0]  n;
        logic        done;
        v    = '0;
        n    = 4'd0;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!done && i < maxn) begin
                v = v | ({57'd0, b[i*8 +: 7]} << (7 * i));
                n = n + 4'd1;
                if (!b[i*8 + 7] || i == maxn - 1) begin
                    done = 1'b1;
                    if (b[i*8 + 6] && (7 * (i + 1)) < 64) begin
                        v = v | (~64'd0 << (7 * (i + 1)));
                    end
                end
            end
        end
        return {n, v};
    endfunction

    assign w_opcode  = mem_data[7:0];
    assign w_top_idx = r_sp[2:0] - 3'd1;
    assign w_sec_idx = r_sp[2:0] - 3'd2;
    assign w_b       = r_val[w_top_idx][31:0];
    assign w_a       = r_val[w_sec_idx][31:0];
    assign w_b_i32   = (r_type[w_top_idx] == T_I32);
    assign w_a_i32   = (r_type[w_sec_idx] == T_I32);
    assign w_full    = (r_sp == 4'd8);
    assign w_empty   = (r_sp == 4'd0);
    assign w_leb32   = leb_decode(mem_data[87:8], 5);
    assign w_leb64   = leb_decode(mem_data[87:8], 10);
    assign w_unused  = ^{mem_data[127:88], w_leb32[63:32]};

    always_comb begin
        w_alu = 32'd0;
        case (w_opcode)
            8'h46:   w_alu = {31'd0, (w_a == w_b)};
            8'h6A:   w_alu = w_a + w_b;
            8'h6B:   w_alu = w_a - w_b;
            8'h71:   w_alu = w_a & w_b;
            8'h72:   w_alu = w_a | w_b;
            8'h73:   w_alu = w_a ^ w_b;
            default: w_alu = 32'd0;
        endcase
    end

    // Execute-stage decode: a non-zero w_exec_trap suppresses every stack and pc update.
    always_comb begin
        w_exec_trap = TRAP_RUN;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_sp[2:0];
        w_wr_val    = '0;
        w_wr_type   = T_I32;
        w_sp_next   = r_sp;
        w_len       = 4'd1;
        if (mem_error) begin
            w_exec_trap = TRAP_MEM;
        end else begin
            case (w_opcode)
                8'h0B: w_exec_trap = TRAP_END;
                8'h1A: begin
                    if (w_empty) w_exec_trap = TRAP_UNDER;
                    else         w_sp_next   = r_sp - 4'd1;
                end
                8'h41: begin
                    if (w_full) begin
                        w_exec_trap = TRAP_OVER;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_val  = {32'd0, w_leb32[31:0]};
                        w_sp_next = r_sp + 4'd1;
                        w_len     = 4'd1 + w_leb32[67:64];
                    end
                end
                8'h42: begin
                    if (USE_64B == 0) begin
                        w_exec_trap = TRAP_UNK;
                    end else if (w_full) begin
                        w_exec_trap = TRAP_OVER;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_val  = w_leb64[63:0];
                        w_wr_type = T_I64;
                        w_sp_next = r_sp + 4'd1;
                        w_len     = 4'd1 + w_leb64[67:64];
                    end
                end
                8'h43, 8'h44: begin
                    if (HAS_FPU == 0) begin
                        w_exec_trap = TRAP_UNK;
                    end else if (w_full) begin
                        w_exec_trap = TRAP_OVER;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_sp_next = r_sp + 4'd1;
                        if (w_opcode == 8'h43) begin
                            w_wr_val  = {32'd0, mem_data[39:8]};
                            w_wr_type = T_F32;
                            w_len     = 4'd5;
                        end else begin
                            w_wr_val  = mem_data[71:8];
                            w_wr_type = T_F64;
                            w_len     = 4'd9;
                        end
                    end
                end
                8'h45: begin
                    if (w_empty) begin
                        w_exec_trap = TRAP_UNDER;
                    end else if (!w_b_i32) begin
                        w_exec_trap = TRAP_TYPE;
                    end else begin
                        w_wr_en  = 1'b1;
                        w_wr_idx = w_top_idx;
                        w_wr_val = {63'd0, (w_b == 32'd0)};
                    end
                end
                8'h46, 8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73: begin
                    if (r_sp < 4'd2) begin
                        w_exec_trap = TRAP_UNDER;
                    end else if (!w_a_i32 || !w_b_i32) begin
                        w_exec_trap = TRAP_TYPE;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = w_sec_idx;
                        w_wr_val  = {32'd0, w_alu};
                        w_sp_next = r_sp - 4'd1;
                    end
                end
                default: w_exec_trap = TRAP_UNK;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: w_state_next = S_EXEC;
            S_EXEC:  w_state_next = (w_exec_trap != TRAP_RUN) ? S_HALT : S_FETCH;
            default: w_state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_sp    <= 4'd0;
            r_trap  <= TRAP_RUN;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_EXEC) begin
                if (w_exec_trap != TRAP_RUN) begin
                    r_trap <= w_exec_trap;
                end else begin
                    r_pc <= r_pc + PC_W'(w_len);
                    r_sp <= w_sp_next;
                    if (w_wr_en) begin
                        r_val[w_wr_idx]  <= w_wr_val;
                        r_type[w_wr_idx] <= w_wr_type;
                    end
                end
            end
        end
    end

    // Memory returns the 16 bytes at mem_addr one cycle after FETCH, so EXEC sees them.
    always_comb begin
        mem_addr    = r_pc;
        mem_extra   = 4'd15;
        trap        = r_trap;
        o_dbg_state = r_state;
        result_empty = w_empty;
        if (w_empty) begin
            result      = 64'd0;
            result_type = T_I32;
        end else begin
            result      = r_val[w_top_idx];
            result_type = r_type[w_top_idx];
        end
    end
endmodule

// File: tb/tb_core.sv
// Bench for core: a registered ROM model, an instruction-level interpreter compared every cycle,
// and directed programs with hand-computed final values.
module tb_core;
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [63:0]   result;
    logic [1:0]    result_type;
    logic          result_empty;
    logic [3:0]    trap;
    logic [4:0]    mem_addr;
    logic [3:0]    mem_extra;
    logic [127:0]  mem_data = '0;
    logic          mem_error = 1'b0;
    logic [1:0]    dbg_state;

    logic [63:0]   d0_result;
    logic [1:0]    d0_result_type;
    logic          d0_result_empty;
    logic [3:0]    d0_trap;
    logic [4:0]    d0_mem_addr;
    logic [3:0]    d0_mem_extra;
    logic [1:0]    d0_dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] mem [0:31];
    int ub = 31;

    // Interpreter state
    logic [63:0] m_val[$];
    logic [1:0]  m_typ[$];
    int          m_pc   = 0;
    logic [3:0]  m_trap = 4'd0;
    bit          m_exec = 1'b0;
    bit          m_halt = 1'b0;

    always #5 clk = ~clk;

    core u_dut (
        .clk(clk), .reset(reset), .result(result), .result_type(result_type),
        .result_empty(result_empty), .trap(trap), .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_data(mem_data), .mem_error(mem_error), .o_dbg_state(dbg_state)
    );

    core #(.HAS_FPU(0), .USE_64B(0), .MEM_DEPTH(4)) u_dut0 (
        .clk(clk), .reset(reset), .result(d0_result), .result_type(d0_result_type),
        .result_empty(d0_result_empty), .trap(d0_trap), .mem_addr(d0_mem_addr),
        .mem_extra(d0_mem_extra), .mem_data(mem_data), .mem_error(mem_error),
        .o_dbg_state(d0_dbg_state)
    );

    function automatic logic [7:0] mbyte(input int a);
        if (a >= 0 && a <= ub && a < 32) return mem[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) mem_data[i*8 +: 8] <= mbyte(int'(mem_addr) + i);
        mem_error <= (int'(mem_addr) > ub);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_stop(input logic [3:0] t);
        m_trap = t;
        m_halt = 1'b1;
    endtask

    task automatic m_push(input logic [63:0] v, input logic [1:0] t, input int len);
        if (m_val.size() == 8) begin
            m_stop(4'd3);
        end else begin
            m_val.push_back(v);
            m_typ.push_back(t);
            m_pc += len;
        end
    endtask

    task automatic m_leb(input int addr, input int maxn, output logic [63:0] v, output int n);
        logic [7:0] byt;
        int shift;
        v = '0;
        shift = 0;
        n = 0;
        do begin
            byt = mbyte(addr + n);
            v = v | (64'(byt[6:0]) << shift);
            shift += 7;
            n++;
        end while (byt[7] && n < maxn);
        if (byt[6] && shift < 64) v = v | (~64'd0 << shift);
    endtask

    task automatic m_binop(input logic [7:0] op);
        logic [31:0] a, b, r;
        if (m_val.size() < 2) begin
            m_stop(4'd2);
        end else if (m_typ[m_typ.size()-1] != 2'd0 || m_typ[m_typ.size()-2] != 2'd0) begin
            m_stop(4'd6);
        end else begin
            b = m_val[m_val.size()-1][31:0];
            a = m_val[m_val.size()-2][31:0];
            case (op)
                8'h46:   r = (a == b) ? 32'd1 : 32'd0;
                8'h6A:   r = a + b;
                8'h6B:   r = a - b;
                8'h71:   r = a & b;
                8'h72:   r = a | b;
                default: r = a ^ b;
            endcase
            void'(m_val.pop_back());
            void'(m_typ.pop_back());
            m_val[m_val.size()-1] = {32'd0, r};
            m_pc += 1;
        end
    endtask

    task automatic model_exec();
        logic [7:0]  op;
        logic [63:0] v;
        int n;
        if (m_pc > ub) begin
            m_stop(4'd5);
            return;
        end
        op = mbyte(m_pc);
        case (op)
            8'h0B: m_stop(4'd1);
            8'h1A: begin
                if (m_val.size() == 0) begin
                    m_stop(4'd2);
                end else begin
                    void'(m_val.pop_back());
                    void'(m_typ.pop_back());
                    m_pc += 1;
                end
            end
            8'h41: begin m_leb(m_pc + 1, 5, v, n); m_push({32'd0, v[31:0]}, 2'd0, 1 + n); end
            8'h42: begin m_leb(m_pc + 1, 10, v, n); m_push(v, 2'd1, 1 + n); end
            8'h43: begin
                v = {32'd0, mbyte(m_pc+4), mbyte(m_pc+3), mbyte(m_pc+2), mbyte(m_pc+1)};
                m_push(v, 2'd2, 5);
            end
            8'h44: begin
                v = '0;
                for (int i = 8; i >= 1; i--) v = {v[55:0], mbyte(m_pc + i)};
                m_push(v, 2'd3, 9);
            end
            8'h45: begin
                if (m_val.size() == 0) m_stop(4'd2);
                else if (m_typ[m_typ.size()-1] != 2'd0) m_stop(4'd6);
                else begin
                    m_val[m_val.size()-1] = (m_val[m_val.size()-1][31:0] == 32'd0) ? 64'd1 : 64'd0;
                    m_pc += 1;
                end
            end
            8'h46, 8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73: m_binop(op);
            default: m_stop(4'd4);
        endcase
    endtask

    // Every instruction is a fetch edge followed by an execute edge; reset wins over both.
    always @(posedge clk) begin
        if (reset) begin
            m_val.delete();
            m_typ.delete();
            m_pc   = 0;
            m_trap = 4'd0;
            m_exec = 1'b0;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (!m_exec) begin
                m_exec = 1'b1;
            end else begin
                model_exec();
                m_exec = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_val.size() == 0) begin
            chk("result", result, 64'd0);
            chk("result_type", 64'(result_type), 64'd0);
        end else begin
            chk("result", result, m_val[m_val.size()-1]);
            chk("result_type", 64'(result_type), 64'(m_typ[m_typ.size()-1]));
        end
        chk("result_empty", 64'(result_empty), 64'(m_val.size() == 0));
        chk("trap", 64'(trap), 64'(m_trap));
        if (!m_exec && !m_halt) begin
            chk("mem_addr", 64'(mem_addr), 64'(m_pc[4:0]));
            chk("mem_extra", 64'(mem_extra), 64'd15);
        end
    end

    // Program bytes are given first-byte-leftmost in a concatenation of n bytes.
    task automatic load(input logic [255:0] p, input int n);
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        for (int i = 0; i < n; i++) mem[i] = p[(n-1-i)*8 +: 8];
    endtask

    task automatic run_prog(input logic [255:0] p, input int n, input int bound, input int cycles);
        @(posedge clk);
        #1 reset = 1'b1;
        load(p, n);
        ub = bound;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [47:0] P_SUB01 = {8'h41, 8'h00, 8'h41, 8'h01, 8'h6B, 8'h0B};

    initial begin
        load({8'h41, 8'h03, 8'h41, 8'h02, 8'h6B, 8'h0B}, 6);
        ub = 31;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("poweron_result", result, 64'd1);
        chk("poweron_type", 64'(result_type), 64'd0);
        chk("poweron_empty", 64'(result_empty), 64'd0);
        chk("poweron_trap", 64'(trap), 64'd1);

        run_prog(256'(P_SUB01), 6, 31, 30);
        chk("sub_wrap_result", result, 64'h0000_0000_FFFF_FFFF);
        chk("sub_wrap_trap", 64'(trap), 64'd1);

        run_prog({8'h6B}, 1, 31, 30);
        chk("underflow_trap", 64'(trap), 64'd2);
        chk("underflow_empty", 64'(result_empty), 64'd1);

        run_prog({9{8'h41, 8'h01}}, 18, 31, 40);
        chk("overflow_trap", 64'(trap), 64'd3);
        chk("overflow_result", result, 64'd1);

        run_prog({8'hFF}, 1, 31, 30);
        chk("unknown_trap", 64'(trap), 64'd4);

        run_prog({8'h42, 8'h01, 8'h41, 8'h01, 8'h6A}, 5, 31, 30);
        chk("type_trap", 64'(trap), 64'd6);
        chk("type_result", result, 64'd1);

        run_prog({8'h41, 8'h80, 8'h01, 8'h42, 8'h7F, 8'h0B}, 6, 31, 30);
        chk("i64_neg_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("i64_neg_type", 64'(result_type), 64'd1);

        run_prog({8'h41, 8'hE5, 8'h8E, 8'h26, 8'h41, 8'h7F, 8'h6A, 8'h0B}, 8, 31, 30);
        chk("leb_add_result", result, 64'h0000_0000_0009_8764);

        run_prog({8'h41, 8'h05, 8'h41, 8'h05, 8'h46, 8'h45, 8'h0B}, 7, 31, 30);
        chk("eq_eqz_result", result, 64'd0);

        run_prog({8'h41, 8'h0C, 8'h41, 8'h0A, 8'h71, 8'h41, 8'h03, 8'h72,
                  8'h41, 8'h0F, 8'h73, 8'h0B}, 12, 31, 40);
        chk("logic_result", result, 64'd4);

        run_prog({8'h41, 8'h07, 8'h41, 8'h09, 8'h1A, 8'h0B}, 6, 31, 30);
        chk("drop_result", result, 64'd7);

        run_prog({8'h1A}, 1, 31, 30);
        chk("drop_empty_trap", 64'(trap), 64'd2);

        run_prog({8'h41, 8'h01}, 2, 1, 30);
        chk("memerr_trap", 64'(trap), 64'd5);
        chk("memerr_result", result, 64'd1);

        run_prog({8'h43, 8'h00, 8'h00, 8'h80, 8'h3F, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'hF0, 8'h3F, 8'h0B}, 15, 31, 30);
        chk("f64_result", result, 64'h3FF0_0000_0000_0000);
        chk("f64_type", 64'(result_type), 64'd3);
        chk("nofpu_trap", 64'(d0_trap), 64'd4);

        run_prog({8'h42, 8'h01, 8'h0B}, 3, 31, 30);
        chk("i64_type", 64'(result_type), 64'd1);
        chk("no64_trap", 64'(d0_trap), 64'd4);

        // Reset lands on the EXEC edge of the second instruction.
        @(posedge clk);
        #1 reset = 1'b1;
        load(256'(P_SUB01), 6);
        ub = 31;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_trap", 64'(trap), 64'd0);
        chk("midreset_empty", 64'(result_empty), 64'd1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("midreset_rerun", result, 64'h0000_0000_FFFF_FFFF);

        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("haltreset_trap", 64'(trap), 64'd0);
        chk("haltreset_empty", 64'(result_empty), 64'd1);
        chk("haltreset_result", result, 64'd0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("haltreset_rerun_trap", 64'(trap), 64'd1);
        chk("haltreset_rerun", result, 64'h0000_0000_FFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/core.md
CORE -- requirements
Module: core

Interface
REQ-001 Parameter HAS_FPU, default 1: when 1, f32/f64 result types are legal; when 0, any f32/f64 opcode traps as unknown.
REQ-002 Parameter USE_64B, default 1: when 1, i64 opcodes are legal; when 0, they trap as unknown.
REQ-003 Parameter MEM_DEPTH, default 4: the byte address is MEM_DEPTH+1 bits wide.
REQ-004 clk  input  1  single system clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 result  output  64  top-of-stack value; i32 values are zero-extended to 64 bits.
REQ-007 result_type  output  2  type of the top of stack: 0=i32, 1=i64, 2=f32, 3=f64.
REQ-008 result_empty  output  1  1 when the operand stack is empty.
REQ-009 trap  output  4  status code: 0=running, 1=ended, 2=stack underflow, 3=stack overflow, 4=unknown opcode, 5=memory error, 6=type mismatch.
REQ-010 mem_addr  output  MEM_DEPTH+1  byte address of the fetch.
REQ-011 mem_extra  output  4  number of extra bytes requested beyond the first.
REQ-012 mem_data  input  128  fetched bytes, little-endian: bits [7:0] hold the byte at mem_addr.
REQ-013 mem_error  input  1  1 when the fetch address is outside the memory bounds.

Function
REQ-014 Memory contract (genrom): mem_data and mem_error are registered and valid one cycle after mem_addr is presented; bytes past the end of memory read as 0; mem_error=1 only when mem_addr itself is outside [lower_bound, upper_bound].
REQ-015 The core is a WebAssembly stack machine with an 8-entry operand stack; each entry is a 64-bit value plus a 2-bit type tag.
REQ-016 The FSM has three states: FETCH, EXEC and HALT; every instruction takes exactly 2 cycles.
REQ-017 FETCH: drive mem_addr=pc and mem_extra=15, then go to EXEC.
REQ-018 EXEC: decode mem_data[7:0] as the opcode, execute it, advance pc by the instruction length, then return to FETCH.
REQ-019 EXEC with mem_error=1: trap=5 and go to HALT.
REQ-020 Supported opcodes: 0x0B end, 0x1A drop, 0x41 i32.const, 0x42 i64.const, 0x45 i32.eqz, 0x46 i32.eq, 0x6A i32.add, 0x6B i32.sub, 0x71 i32.and, 0x72 i32.or, 0x73 i32.xor.
REQ-021 i32.const: the immediate is signed LEB128 of at most 5 bytes, truncated to 32 bits; i64.const: signed LEB128 of at most 10 bytes.
REQ-022 Binary i32 operations pop b (top), then a, and push a op b modulo 2^32.
REQ-023 i32.sub pushes a-b with wrap-around; for example 0-1 = 0xFFFFFFFF.
REQ-024 i32.eq pushes 1 or 0; i32.eqz pushes 1 when the operand is 0, otherwise 0.
REQ-025 An operand whose type is not i32 in an i32 operation: trap=6 and go to HALT.
REQ-026 Pop from an empty stack (or too few operands): trap=2 and go to HALT; the stack is unchanged.
REQ-027 Push onto a full stack (8 entries): trap=3 and go to HALT; the stack is unchanged.
REQ-028 Undefined opcode, or an opcode disabled by a parameter: trap=4 and go to HALT.
REQ-029 end: trap=1 and go to HALT.
REQ-030 HALT: no further fetches; the stack, result outputs and trap hold until reset.
REQ-031 result, result_type and result_empty are combinational from the stack pointer and top entry; they update in the cycle after the EXEC that changes the stack.
REQ-032 While the stack is empty: result=0 and result_type=0.

Reset
REQ-033 On reset (synchronous): pc=0, state=FETCH, stack empty, result=0, result_type=0, result_empty=1, trap=0.
REQ-034 Reset asserted mid-instruction takes priority over any EXEC action in the same cycle.
REQ-035 All registers have power-on initial values equal to their reset values, so the core runs without ever seeing reset.

Verification
REQ-036 Program 41 03 41 02 6B 0B, reset never asserted -> by cycle 12: result=1, result_type=0, result_empty=0, trap=1.
REQ-037 Program 41 00 41 01 6B 0B -> result=0x00000000FFFFFFFF, result_type=0, trap=1.
REQ-038 Program 6B -> trap=2, result_empty=1.
REQ-039 Program of nine 41 01 pairs -> trap=3 after the ninth push; the stack holds 8 entries.
REQ-040 Program FF -> trap=4; program 42 01 41 01 6A -> trap=6.
REQ-041 Reset pulsed while halted -> trap=0, result_empty=1, and the program re-executes from pc=0.
